reg_dump_tx: RTL and testbench

REG_DUMP_TX -- requirements
Module: reg_dump_tx

---
 rtl/reg_dump_tx_pkg.sv | 24 ++
 rtl/dump_skid.sv | 48 ++++
 rtl/reg_dump_tx.sv | 132 +++++++++++++
 tb/tb_reg_dump_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_tx_pkg.sv
// Shared types and constants for the register dump transmitter.
// Holds the FSM state encoding and the header word layout.
package reg_dump_tx_pkg;

  typedef enum logic [2:0] {
    StRun,
    StSnap,
    StHdr,
    StRegs,
    StDone
  } state_e;

  localparam int unsigned NREGS_DEFAULT   = 32;
  localparam int unsigned HDR_TIMEOUT_BIT = 31;

  // Header word: timeout flag on top, low 31 bits of the latched cycle count below.
  function automatic logic [31:0] make_header(input logic timeout, input logic [31:0] count);
    logic [31:0] hdr;
    hdr                  = count;
    hdr[HDR_TIMEOUT_BIT] = timeout;
    return hdr;
  endfunction

endpackage

// File: rtl/dump_skid.sv
// Output register for the dump stream: holds the presented beat stable until it is
// accepted, and accepts a new beat in the same cycle the current one transfers.
module dump_skid (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  input  logic [5:0]  in_index_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [5:0]  out_index_o,
  output logic        out_last_o
);

  logic        valid_q;
  logic [31:0] data_q;
  logic [5:0]  index_q;
  logic        last_q;

  assign in_ready_o = !valid_q || out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        data_q  <= in_data_i;
        index_q <= in_index_i;
        last_q  <= in_last_i;
      end else begin
        last_q  <= 1'b0;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_index_o = index_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/reg_dump_tx.sv
// Counts cycles until the CPU halts (or a cycle budget expires), snapshots the register
// file and streams a header plus every register over a valid/ready interface.
module reg_dump_tx
  import reg_dump_tx_pkg::*;
#(
  parameter int unsigned MAX_CLOCKS = 100000,
  parameter int unsigned NREGS      = NREGS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        completed,
  input  logic [31:0] registers [0:NREGS-1],
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_index,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int unsigned IdxW    = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [31:0] MaxCnt  = 32'(MAX_CLOCKS);
  localparam logic [5:0]  LastIdx = 6'(NREGS);

  state_e      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        timeout_q, timeout_d;
  logic [5:0]  nxt_q, nxt_d;
  logic [31:0] snap_q [0:NREGS-1];
  logic        snap_capture;

  logic        in_valid;
  logic [31:0] in_data;
  logic [5:0]  in_index;
  logic        in_last;
  logic        in_ready;
  logic        beat_xfer;

  assign beat_xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      count_q   <= '0;
      timeout_q <= 1'b0;
      nxt_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      nxt_q     <= nxt_d;
    end
  end

  // Snapshot needs no reset: it is only read after a capture.
  always_ff @(posedge clk) begin
    if (snap_capture) begin
      snap_q <= registers;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    timeout_d    = timeout_q;
    nxt_d        = nxt_q;
    snap_capture = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_index     = '0;
    in_last      = 1'b0;

    unique case (state_q)
      StRun: begin
        // Counter freezes on the trigger cycle so the header reports that cycle's count.
        if (completed || (count_q == MaxCnt)) begin
          state_d   = StSnap;
          timeout_d = !completed;
        end else begin
          count_d = count_q + 32'd1;
        end
      end
      StSnap: begin
        // Output register is empty here, so the header is always accepted.
        snap_capture = 1'b1;
        in_valid     = 1'b1;
        in_data      = make_header(timeout_q, count_q);
        nxt_d        = 6'd1;
        state_d      = StHdr;
      end
      StHdr, StRegs: begin
        if (nxt_q <= LastIdx) begin
          in_valid = 1'b1;
          in_data  = snap_q[IdxW'(nxt_q - 6'd1)];
          in_index = nxt_q;
          in_last  = (nxt_q == LastIdx);
          if (in_ready) begin
            nxt_d = nxt_q + 6'd1;
          end
        end
        if (state_q == StHdr && beat_xfer) begin
          state_d = StRegs;
        end else if (state_q == StRegs && beat_xfer && out_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
      end
      default: state_d = StRun;
    endcase
  end

  assign busy = (state_q == StSnap) || (state_q == StHdr) || (state_q == StRegs);
  assign done = (state_q == StDone);

  dump_skid u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_index_i  (in_index),
    .in_last_i   (in_last),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_index_o (out_index),
    .out_last_o  (out_last)
  );

endmodule

// File: tb/tb_reg_dump_tx.sv
// Randomized scoreboard bench for reg_dump_tx: expected beats are queued when a dump is
// triggered and an independent monitor checks every accepted beat and every stall.
module tb_reg_dump_tx;

  localparam int unsigned MAXC = 60;
  localparam int unsigned NR   = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  index;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        completed = 1'b0;
  logic [31:0] regs [0:NR-1];
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [5:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    ready_rand = 1'b0;

  reg_dump_tx #(
    .MAX_CLOCKS (MAXC),
    .NREGS      (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .completed (completed),
    .registers (regs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: header then every register in order, last flag on the final one.
  task automatic push_dump(input bit timeout, input int unsigned count);
    beat_t b;
    b.data  = {timeout, count[30:0]};
    b.index = 6'd0;
    b.last  = 1'b0;
    exp_q.push_back(b);
    for (int k = 0; k < NR; k++) begin
      b.data  = regs[k];
      b.index = 6'(k + 1);
      b.last  = (k == NR - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic rand_regs();
    for (int k = 0; k < NR; k++) regs[k] = $urandom;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    completed = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_index", 32'(out_index), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !done; i++) @(posedge clk);
    #1;
    chk("done_flag", 32'(done), 32'd1);
    chk("busy_clear", 32'(busy), 32'd0);
    chk("all_beats_seen", 32'(exp_q.size()), 32'd0);
    // Holding completed high in DONE must not restart a dump.
    completed = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_restart", 32'(out_valid), 32'd0);
    completed = 1'b0;
  endtask

  // n > 0: raise completed after n counted cycles; n == 0: let the budget expire.
  task automatic run_dump(input int unsigned n);
    do_reset();
    if (n == 0) begin
      push_dump(1'b1, MAXC);
      repeat (MAXC + 2) @(posedge clk);
      #1;
      rand_regs();
      completed = 1'b1;
    end else begin
      repeat (n) @(posedge clk);
      #1;
      completed = 1'b1;
      push_dump(1'b0, n);
      @(posedge clk);
      #1;
      chk("latency_1", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("latency_2", 32'(out_valid), 32'd1);
      rand_regs();
      completed = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares accepted beats against the queue and checks stall stability.
  initial begin
    beat_t got;
    beat_t want;
    beat_t prev;
    bit    prev_stall;
    prev_stall = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        got = '{data: out_data, index: out_index, last: out_last};
        if (prev_stall) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_hold", {got.data[31:7] ^ prev.data[31:7],
                             got.data[6:0] ^ prev.data[6:0]}
                            | {25'd0, got.index ^ prev.index, got.last ^ prev.last}, 32'd0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat_index", 32'(out_index), 32'hFFFF_FFFF);
          end else begin
            want = exp_q.pop_front();
            chk($sformatf("beat%0d_data", want.index), got.data, want.data);
            chk($sformatf("beat%0d_index", want.index), 32'(got.index), 32'(want.index));
            chk($sformatf("beat%0d_last", want.index), 32'(got.last), 32'(want.last));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev       = got;
      end
    end
  end

  initial begin
    rand_regs();

    // Directed dump: r5 = 7, r31 = -3, completed after 50 cycles.
    regs[5]  = 32'd7;
    regs[31] = 32'hFFFF_FFFD;
    run_dump(50);

    // Budget expiry without completed.
    rand_regs();
    run_dump(0);

    // Random backpressure with random halt points.
    ready_rand = 1'b1;
    for (int t = 0; t < 3; t++) begin
      rand_regs();
      run_dump($urandom_range(1, MAXC - 1));
    end

    // Halt on the same cycle the budget expires: not a timeout.
    rand_regs();
    run_dump(MAXC);

    // Reset in the middle of a dump, then a fresh full dump.
    ready_rand = 1'b0;
    rand_regs();
    do_reset();
    repeat (30) @(posedge clk);
    #1;
    completed = 1'b1;
    push_dump(1'b0, 30);
    for (int i = 0; i < 200 && !(out_valid && out_index == 6'd10); i++) begin
      @(posedge clk);
      #1;
    end
    chk("reached_beat10", 32'(out_index), 32'd10);
    rst = 1'b1;
    #1;
    chk("midreset_valid", 32'(out_valid), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    rand_regs();
    run_dump(25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
